// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_loader_pkg: shared types and constants for the imem loader     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package imem_loader_pkg;

  localparam int INST_W         = 32;
  localparam int BYTES_PER_INST = 4;
  localparam int IMEM_ADDR_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Length byte 0 selects the full RAM; anything past the end is clamped.
  function automatic int unsigned clamp_len(input logic [7:0] n, input int unsigned depth);
    int unsigned n_ext;
    n_ext = {24'd0, n};
    if (n == 8'd0 || n_ext > depth) begin
      return depth;
    end
    return n_ext;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_loader_byte_packer: big-endian byte-to-word shift register     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              shift_en_i,
  input  logic [7:0]        byte_i,
  output logic [INST_W-1:0] word_o,
  output logic              word_complete_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_INST - 1);

  logic [INST_W-1:0] word_q, word_d;
  logic [1:0]        idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (shift_en_i) begin
      word_d = {word_q[INST_W-9:0], byte_i};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o          = word_q;
  assign word_complete_o = shift_en_i && (idx_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_loader: length-prefixed byte stream to instruction RAM writer  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] wdata_q, wdata_d;

  logic              xfer;
  logic              pk_clear;
  logic              pk_shift;
  logic              pk_complete;
  logic [INST_W-1:0] pk_word;
  logic [ADDR_W:0]   cnt_inc;

  assign rx_ready = (state_q == ST_LEN) || (state_q == ST_DATA);
  assign xfer     = rx_valid && rx_ready;
  assign pk_shift = (state_q == ST_DATA) && xfer;
  assign cnt_inc  = cnt_q + (ADDR_W + 1)'(1);

  imem_loader_byte_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (pk_clear),
    .shift_en_i      (pk_shift),
    .byte_i          (rx_data),
    .word_o          (pk_word),
    .word_complete_o (pk_complete)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pk_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          cnt_d   = '0;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (xfer) begin
          len_d    = (ADDR_W + 1)'(clamp_len(rx_data, DEPTH));
          addr_d   = '0;
          pk_clear = 1'b1;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_complete) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wdata_d  = pk_word;
        cnt_d    = cnt_inc;
        pk_clear = 1'b1;
        if (cnt_inc == len_q) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Write strobe is masked by rst so a reset landing on WRITE never commits a word.
  assign imem_we    = (state_q == ST_WRITE) && !rst;
  assign imem_addr  = addr_q;
  assign imem_wdata = (state_q == ST_WRITE) ? pk_word : wdata_q;
  assign cpu_hold   = (state_q != ST_IDLE);
  assign load_done  = (state_q == ST_DONE);
  assign word_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_imem_loader: directed self-checking bench for imem_loader        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   word_cnt;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Write log and handshake monitors, sampled on the active edge.
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int  accepted    = 0;
  int  done_pulses = 0;
  int  ready_in_we = 0;
  int  hold_gaps   = 0;
  bit  hold_mon    = 1'b0;

  always @(posedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      if (rx_ready) ready_in_we++;
    end
    if (rx_valid && rx_ready) accepted++;
    if (load_done) done_pulses++;
    if (hold_mon && !cpu_hold) hold_gaps++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("rx_ready_timeout", 32'(rx_ready), 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int i = 0; i < 4; i++) begin
      tick(int'($urandom_range(gapmax, 0)));
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic start_load(input logic [7:0] n);
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    send_byte(n);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!load_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("load_done_seen", 32'(load_done), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int a0;
    int d0;
    int g0;
    int r0;
    logic [31:0] pw;

    rst = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(3);
    rst = 1'b0;
    check("rst_rx_ready",   32'(rx_ready),   0);
    check("rst_imem_we",    32'(imem_we),    0);
    check("rst_imem_addr",  32'(imem_addr),  0);
    check("rst_imem_wdata", imem_wdata,      0);
    check("rst_cpu_hold",   32'(cpu_hold),   0);
    check("rst_load_done",  32'(load_done),  0);
    check("rst_word_cnt",   32'(word_cnt),   0);

    // N=2, back-to-back bytes
    base = wa.size();
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    check("t1_hold_len",  32'(cpu_hold), 1);
    check("t1_ready_len", 32'(rx_ready), 1);
    send_byte(8'h02);
    send_word(32'h2008_0005, 0);
    check("t1_we0",    32'(imem_we),   1);
    check("t1_addr0",  32'(imem_addr), 0);
    check("t1_wdata0", imem_wdata,     32'h2008_0005);
    check("t1_ready_write", 32'(rx_ready), 0);
    send_word(32'h2009_000A, 0);
    check("t1_we1",    32'(imem_we),   1);
    check("t1_addr1",  32'(imem_addr), 1);
    check("t1_wdata1", imem_wdata,     32'h2009_000A);
    tick(1);
    check("t1_done",      32'(load_done), 1);
    check("t1_hold_done", 32'(cpu_hold),  1);
    check("t1_cnt",       32'(word_cnt),  2);
    tick(1);
    check("t1_hold_idle",  32'(cpu_hold),  0);
    check("t1_done_idle",  32'(load_done), 0);
    check("t1_addr_hold",  32'(imem_addr), 1);
    check("t1_wdata_hold", imem_wdata,     32'h2009_000A);
    check("t1_we_idle",    32'(imem_we),   0);
    check("t1_nwrites",    32'(wa.size() - base), 2);

    // Same stream with gaps
    base = wa.size();
    r0 = ready_in_we;
    start_load(8'h02);
    send_word(32'h2008_0005, 1);
    send_word(32'h2009_000A, 3);
    wait_done();
    check("t2_cnt",     32'(word_cnt), 2);
    check("t2_nwrites", 32'(wa.size() - base), 2);
    check("t2_addr0",   32'(wa[base]),   0);
    check("t2_wdata0",  wd[base],        32'h2008_0005);
    check("t2_addr1",   32'(wa[base+1]), 1);
    check("t2_wdata1",  wd[base+1],      32'h2009_000A);
    check("t2_ready_in_write", 32'(ready_in_we - r0), 0);
    tick(1);

    // N=0 selects full depth
    base = wa.size();
    g0 = hold_gaps;
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    hold_mon = 1'b1;
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      pw = {8'(i), ~8'(i), 8'h5A, 8'(i + 1)};
      send_word(pw, 0);
    end
    wait_done();
    hold_mon = 1'b0;
    check("t3_cnt",       32'(word_cnt), 64);
    check("t3_nwrites",   32'(wa.size() - base), 64);
    check("t3_hold_gaps", 32'(hold_gaps - g0), 0);
    check("t3_last_addr", 32'(imem_addr), 63);
    for (int i = 0; i < 64; i++) begin
      pw = {8'(i), ~8'(i), 8'h5A, 8'(i + 1)};
      check("t3_addr",  32'(wa[base+i]), 32'(i));
      check("t3_wdata", wd[base+i],      pw);
    end
    tick(1);

    // N=200 clamps to 64
    base = wa.size();
    d0 = done_pulses;
    start_load(8'hC8);
    for (int i = 0; i < 64; i++) send_word(32'h1000_0000 + 32'(i), 0);
    wait_done();
    check("t4_cnt",        32'(word_cnt), 64);
    check("t4_nwrites",    32'(wa.size() - base), 64);
    check("t4_first_addr", 32'(wa[base]),    0);
    check("t4_last_addr",  32'(wa[base+63]), 63);
    check("t4_last_wdata", wd[base+63],      32'h1000_003F);
    tick(1);
    check("t4_done_pulses", 32'(done_pulses - d0), 1);
    a0 = accepted;
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    tick(4);
    check("t4_ready_idle", 32'(rx_ready), 0);
    rx_valid = 1'b0;
    check("t4_idle_accepted", 32'(accepted - a0), 0);
    check("t4_hold_idle",     32'(cpu_hold), 0);

    // Reset in the middle of word 1
    base = wa.size();
    start_load(8'h03);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_hold_after_rst",  32'(cpu_hold), 0);
    check("t5_ready_after_rst", 32'(rx_ready), 0);
    check("t5_cnt_after_rst",   32'(word_cnt), 0);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tick(5);
    rx_valid = 1'b0;
    check("t5_nwrites", 32'(wa.size() - base), 1);
    check("t5_wdata0",  wd[base], 32'h1122_3344);
    start_load(8'h01);
    send_word(32'h8C01_0000, 2);
    wait_done();
    check("t5_cnt",     32'(word_cnt), 1);
    check("t5_nwrites_fresh", 32'(wa.size() - base), 2);
    check("t5_addr",    32'(wa[base+1]), 0);
    check("t5_wdata",   wd[base+1], 32'h8C01_0000);
    tick(1);

    // load_start held during DATA is ignored
    base = wa.size();
    start_load(8'h01);
    load_start = 1'b1;
    send_word(32'hDEAD_BEEF, 1);
    load_start = 1'b0;
    wait_done();
    check("t6_cnt",     32'(word_cnt), 1);
    check("t6_nwrites", 32'(wa.size() - base), 1);
    check("t6_addr",    32'(wa[base]), 0);
    check("t6_wdata",   wd[base], 32'hDEAD_BEEF);
    tick(1);
    a0 = accepted;
    rx_data  = 8'h3C;
    rx_valid = 1'b1;
    tick(5);
    rx_valid = 1'b0;
    check("t6_idle_accepted", 32'(accepted - a0), 0);
    check("t6_hold_idle",     32'(cpu_hold), 0);
    check("t6_cnt_holds",     32'(word_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
